axis_stereo_gain_v1_0: RTL and testbench

AXI-Stream stereo gain stage that sits directly downstream of the I2S receiver. It consumes 64-bit frames in the format [l_data(24), 8'd0, r_data(24), 8'd0] and applies an independent signed Q2.14 gain to each channel, with rounding, saturation and mute. It emits frames in the same format to the next stream consumer, such as a DMA or the I2S transmitter. The block is a 2-stage valid/ready pipeline with full backpressure support.

---
 rtl/axis_stereo_gain_v1_0.sv | 155 +++++++++++++++
 tb/tb_axis_stereo_gain_v1_0.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/axis_stereo_gain_v1_0.sv
// axis_stereo_gain_v1_0
//   AXI-Stream stereo gain stage. It takes frames in the format
//   [L(24), pad(8), R(24), pad(8)] and applies a signed Q2.14 gain to each
//   channel independently. Each result is rounded half-up, then saturated.
//   Mute forces both captured gains to zero.
//   The block is a two-stage valid/ready pipeline:
//     stage 1 captures the samples, tlast and the gains.
//     stage 2 multiplies, rounds, saturates and registers the output.
//
// Ports
//   aclk, reset           : clock; asynchronous active-high reset
//   s_axis_*              : input stream (tdata/tvalid/tready/tlast)
//   m_axis_*              : output stream; pad bytes are driven to 0
//   gain_l, gain_r        : Q2.14 signed gains, latched when a frame is accepted
//   mute                  : zeroes both gains for frames accepted while it is high
//   sat_clear             : clears the sticky clip flags (a new clip wins)
//   sat_l, sat_r          : sticky per-channel clip flags

// One channel: signed sample x Q2.14 gain, round half-up, saturate to DW bits.
module axis_stereo_gain_v1_0_lane #(
  parameter int DW = 24,
  parameter int GW = 16
) (
  input  logic signed [DW-1:0] samp_i,
  input  logic signed [GW-1:0] gain_i,
  output logic        [DW-1:0] res_o,
  output logic                 clip_o
);
  localparam int PW   = DW + GW;
  localparam int FRAC = GW - 2;

  localparam logic signed [PW-1:0] MAXV = {{(GW+1){1'b0}}, {(DW-1){1'b1}}};
  localparam logic signed [PW-1:0] MINV = {{(GW+1){1'b1}}, {(DW-1){1'b0}}};
  localparam logic signed [PW-1:0] RND  = {{(PW-FRAC){1'b0}}, 1'b1, {(FRAC-1){1'b0}}};

  logic signed [PW-1:0] prod, rnd, shf;
  logic                 hi, lo;

  // The full product magnitude is at most 2^(PW-2), so it fits in PW bits.
  // Adding the rounding constant therefore cannot overflow PW bits either.
  assign prod = $signed({{GW{samp_i[DW-1]}}, samp_i}) *
                $signed({{DW{gain_i[GW-1]}}, gain_i});
  assign rnd  = prod + RND;
  assign shf  = rnd >>> FRAC;
  assign hi   = shf > MAXV;
  assign lo   = shf < MINV;

  assign res_o  = hi ? MAXV[DW-1:0] : (lo ? MINV[DW-1:0] : shf[DW-1:0]);
  assign clip_o = hi | lo;
endmodule

module axis_stereo_gain_v1_0 #(
  parameter int DATA_WIDTH = 24,
  parameter int GAIN_WIDTH = 16
) (
  input  logic                  aclk,
  input  logic                  reset,
  input  logic [63:0]           s_axis_tdata,
  input  logic                  s_axis_tvalid,
  output logic                  s_axis_tready,
  input  logic                  s_axis_tlast,
  output logic [63:0]           m_axis_tdata,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic                  m_axis_tlast,
  input  logic [GAIN_WIDTH-1:0] gain_l,
  input  logic [GAIN_WIDTH-1:0] gain_r,
  input  logic                  mute,
  input  logic                  sat_clear,
  output logic                  sat_l,
  output logic                  sat_r
);
  localparam int NUM_LANES = 2;   // lane 1 = left, lane 0 = right
  localparam int PAD       = 32 - DATA_WIDTH;

  logic                                  v1_q, v1_d, last1_q, last1_d;
  logic [NUM_LANES-1:0][DATA_WIDTH-1:0]  samp_q, samp_d;
  logic [NUM_LANES-1:0][GAIN_WIDTH-1:0]  gain_q, gain_d;
  logic                                  v2_q, v2_d, tlast_q, tlast_d;
  logic [63:0]                           tdata_q, tdata_d;
  logic [NUM_LANES-1:0]                  sat_q, sat_d;

  logic [NUM_LANES-1:0][DATA_WIDTH-1:0]  res;
  logic [NUM_LANES-1:0]                  clip;
  logic                                  ld1, ld2;

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    axis_stereo_gain_v1_0_lane #(.DW(DATA_WIDTH), .GW(GAIN_WIDTH)) u_lane (
      .samp_i (samp_q[i]),
      .gain_i (gain_q[i]),
      .res_o  (res[i]),
      .clip_o (clip[i])
    );
  end

  // Each stage loads when it is empty or when the stage after it moves.
  assign ld2 = !v2_q || m_axis_tready;
  assign ld1 = !v1_q || ld2;

  always_comb begin
    v1_d    = v1_q;
    last1_d = last1_q;
    samp_d  = samp_q;
    gain_d  = gain_q;
    v2_d    = v2_q;
    tdata_d = tdata_q;
    tlast_d = tlast_q;
    if (ld1) begin
      v1_d = s_axis_tvalid;
      if (s_axis_tvalid) begin
        samp_d  = {s_axis_tdata[63 -: DATA_WIDTH], s_axis_tdata[31 -: DATA_WIDTH]};
        gain_d  = mute ? '0 : {gain_l, gain_r};
        last1_d = s_axis_tlast;
      end
    end
    if (ld2) begin
      v2_d = v1_q;
      if (v1_q) begin
        tdata_d = {res[1], {PAD{1'b0}}, res[0], {PAD{1'b0}}};
        tlast_d = last1_q;
      end
    end
    // A clip that is loaded in the same cycle as a clear keeps the flag set.
    sat_d = (sat_q & ~{NUM_LANES{sat_clear}}) | ({NUM_LANES{ld2 & v1_q}} & clip);
  end

  always_ff @(posedge aclk or posedge reset) begin
    if (reset) begin
      v1_q    <= 1'b0;
      last1_q <= 1'b0;
      samp_q  <= '0;
      gain_q  <= '0;
      v2_q    <= 1'b0;
      tdata_q <= '0;
      tlast_q <= 1'b0;
      sat_q   <= '0;
    end else begin
      v1_q    <= v1_d;
      last1_q <= last1_d;
      samp_q  <= samp_d;
      gain_q  <= gain_d;
      v2_q    <= v2_d;
      tdata_q <= tdata_d;
      tlast_q <= tlast_d;
      sat_q   <= sat_d;
    end
  end

  assign s_axis_tready = !reset && ld1;
  assign m_axis_tdata  = tdata_q;
  assign m_axis_tvalid = v2_q;
  assign m_axis_tlast  = tlast_q;
  assign sat_l         = sat_q[1];
  assign sat_r         = sat_q[0];
endmodule

// File: tb/tb_axis_stereo_gain_v1_0.sv
// Directed bench for axis_stereo_gain_v1_0. All expected values are hand-computed.
module tb_axis_stereo_gain_v1_0;
  logic        aclk = 1'b0;
  logic        reset;
  logic [63:0] s_axis_tdata;
  logic        s_axis_tvalid, s_axis_tready, s_axis_tlast;
  logic [63:0] m_axis_tdata;
  logic        m_axis_tvalid, m_axis_tready, m_axis_tlast;
  logic [15:0] gain_l, gain_r;
  logic        mute, sat_clear, sat_l, sat_r;

  int total = 0;
  int bad   = 0;

  axis_stereo_gain_v1_0 dut (
    .aclk(aclk), .reset(reset),
    .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid),
    .s_axis_tready(s_axis_tready), .s_axis_tlast(s_axis_tlast),
    .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tready(m_axis_tready), .m_axis_tlast(m_axis_tlast),
    .gain_l(gain_l), .gain_r(gain_r), .mute(mute), .sat_clear(sat_clear),
    .sat_l(sat_l), .sat_r(sat_r)
  );

  always #5 aclk = ~aclk;

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] fr(input logic [23:0] l, input logic [23:0] r,
                                     input logic [7:0] pad);
    return {l, pad, r, pad};
  endfunction

  // Accept one frame (mready=1), then advance to the cycle where it is presented.
  task automatic send1(input logic [23:0] l, input logic [23:0] r, input logic last);
    s_axis_tdata  = fr(l, r, 8'hA5);
    s_axis_tlast  = last;
    s_axis_tvalid = 1'b1;
    tick();
    s_axis_tvalid = 1'b0;
    tick();
  endtask

  initial begin
    reset = 1'b1; s_axis_tdata = '0; s_axis_tvalid = 1'b0; s_axis_tlast = 1'b0;
    m_axis_tready = 1'b1; gain_l = 16'h4000; gain_r = 16'h4000;
    mute = 1'b0; sat_clear = 1'b0;
    tick();
    chk("rst_tready", {63'd0, s_axis_tready}, 64'd0);
    chk("rst_mvalid", {63'd0, m_axis_tvalid}, 64'd0);
    chk("rst_mdata",  m_axis_tdata, 64'd0);
    chk("rst_mlast",  {63'd0, m_axis_tlast}, 64'd0);
    chk("rst_sat",    {62'd0, sat_l, sat_r}, 64'd0);
    tick();
    reset = 1'b0;
    tick();

    // Unity gain with exact two-cycle latency. Input pads are nonzero, output pads must be 0.
    s_axis_tdata = fr(24'h123456, 24'hEDCBAA, 8'hA5); s_axis_tlast = 1'b1;
    s_axis_tvalid = 1'b1;
    #1 chk("unity_tready", {63'd0, s_axis_tready}, 64'd1);
    tick();
    s_axis_tvalid = 1'b0;
    chk("unity_lat1", {63'd0, m_axis_tvalid}, 64'd0);
    tick();
    chk("unity_lat2", {63'd0, m_axis_tvalid}, 64'd1);
    chk("unity_data", m_axis_tdata, 64'h12345600_EDCBAA00);
    chk("unity_last", {63'd0, m_axis_tlast}, 64'd1);
    chk("unity_sat",  {62'd0, sat_l, sat_r}, 64'd0);
    tick();
    chk("unity_drain", {63'd0, m_axis_tvalid}, 64'd0);

    // Rounding at gain 0.5: 3*0.5=1.5 rounds to 2, and -1.5 rounds to -1.
    gain_l = 16'h2000; gain_r = 16'h2000;
    send1(24'h000003, 24'hFFFFFD, 1'b0);
    chk("round_data", m_axis_tdata, fr(24'h000002, 24'hFFFFFF, 8'h00));
    chk("round_last", {63'd0, m_axis_tlast}, 64'd0);

    // Positive clip on the left channel only.
    gain_l = 16'h7FFF; gain_r = 16'h4000;
    send1(24'h700000, 24'h000001, 1'b0);
    chk("satl_data", m_axis_tdata, fr(24'h7FFFFF, 24'h000001, 8'h00));
    chk("satl_flags", {62'd0, sat_l, sat_r}, 64'b10);

    // -2.0 gain: full-scale negative times -2 clips high, and max positive times -2 clips low.
    gain_l = 16'h8000; gain_r = 16'h8000;
    send1(24'h7FFFFF, 24'h800000, 1'b0);
    chk("satr_data", m_axis_tdata, fr(24'h800000, 24'h7FFFFF, 8'h00));
    chk("satr_flags", {62'd0, sat_l, sat_r}, 64'b11);

    sat_clear = 1'b1; tick(); sat_clear = 1'b0;
    chk("sat_cleared", {62'd0, sat_l, sat_r}, 64'b00);

    // A clip and a clear in the same cycle: the set wins.
    gain_l = 16'h7FFF; gain_r = 16'h4000;
    s_axis_tdata = fr(24'h700000, 24'h000001, 8'h00); s_axis_tvalid = 1'b1;
    tick();
    s_axis_tvalid = 1'b0; sat_clear = 1'b1;
    tick();
    sat_clear = 1'b0;
    chk("sat_setwins", {62'd0, sat_l, sat_r}, 64'b10);
    sat_clear = 1'b1; tick(); sat_clear = 1'b0;
    chk("sat_cleared2", {62'd0, sat_l, sat_r}, 64'b00);

    // Backpressure: three frames are offered and exactly two are accepted.
    gain_l = 16'h4000; gain_r = 16'h4000;
    m_axis_tready = 1'b0;
    s_axis_tdata = fr(24'h000001, 24'h000002, 8'hFF); s_axis_tlast = 1'b0; s_axis_tvalid = 1'b1;
    #1 chk("bp_rdyA", {63'd0, s_axis_tready}, 64'd1);
    tick();
    s_axis_tdata = fr(24'h000003, 24'h000004, 8'hFF); s_axis_tlast = 1'b1;
    #1 chk("bp_rdyB", {63'd0, s_axis_tready}, 64'd1);
    tick();
    s_axis_tdata = fr(24'h000005, 24'h000006, 8'hFF); s_axis_tlast = 1'b0;
    #1 chk("bp_rdyC", {63'd0, s_axis_tready}, 64'd0);
    tick();
    chk("bp_full",  {63'd0, s_axis_tready}, 64'd0);
    chk("bp_vld",   {63'd0, m_axis_tvalid}, 64'd1);
    chk("bp_holdA", m_axis_tdata, fr(24'h000001, 24'h000002, 8'h00));
    tick();
    chk("bp_holdA2", m_axis_tdata, fr(24'h000001, 24'h000002, 8'h00));
    chk("bp_lastA",  {63'd0, m_axis_tlast}, 64'd0);
    m_axis_tready = 1'b1;
    #1 chk("bp_rdyC2", {63'd0, s_axis_tready}, 64'd1);
    tick();
    s_axis_tvalid = 1'b0;
    chk("bp_outB",  m_axis_tdata, fr(24'h000003, 24'h000004, 8'h00));
    chk("bp_lastB", {63'd0, m_axis_tlast}, 64'd1);
    tick();
    chk("bp_outC",  m_axis_tdata, fr(24'h000005, 24'h000006, 8'h00));
    chk("bp_lastC", {63'd0, m_axis_tlast}, 64'd0);
    chk("bp_vldC",  {63'd0, m_axis_tvalid}, 64'd1);
    tick();
    chk("bp_drain", {63'd0, m_axis_tvalid}, 64'd0);

    // A gain change between back-to-back frames applies only to the second frame.
    gain_l = 16'h4000;
    s_axis_tdata = fr(24'h100000, 24'h000000, 8'h00); s_axis_tvalid = 1'b1;
    tick();
    gain_l = 16'h2000;
    tick();
    s_axis_tvalid = 1'b0; gain_l = 16'h4000;
    chk("gain_f1", m_axis_tdata, fr(24'h100000, 24'h000000, 8'h00));
    tick();
    chk("gain_f2", m_axis_tdata, fr(24'h080000, 24'h000000, 8'h00));
    chk("gain_vld2", {63'd0, m_axis_tvalid}, 64'd1);
    tick();

    // Mute is sampled at capture and then released.
    mute = 1'b1;
    s_axis_tdata = fr(24'h123456, 24'h654321, 8'hA5); s_axis_tvalid = 1'b1;
    tick();
    s_axis_tvalid = 1'b0; mute = 1'b0;
    tick();
    chk("mute_vld",  {63'd0, m_axis_tvalid}, 64'd1);
    chk("mute_data", m_axis_tdata, 64'd0);
    tick();

    // A reset while two frames are in flight discards them.
    m_axis_tready = 1'b0;
    s_axis_tdata = fr(24'h111111, 24'h222222, 8'h00); s_axis_tvalid = 1'b1;
    tick(); tick();
    s_axis_tvalid = 1'b0;
    chk("rip_vld", {63'd0, m_axis_tvalid}, 64'd1);
    reset = 1'b1;
    #1 chk("rip_vld0", {63'd0, m_axis_tvalid}, 64'd0);
    chk("rip_rdy0", {63'd0, s_axis_tready}, 64'd0);
    tick();
    reset = 1'b0; m_axis_tready = 1'b1;
    tick(); tick();
    chk("rip_nostale", {63'd0, m_axis_tvalid}, 64'd0);
    s_axis_tdata = fr(24'h0000AA, 24'h0000BB, 8'h00); s_axis_tvalid = 1'b1; s_axis_tlast = 1'b1;
    tick();
    s_axis_tvalid = 1'b0;
    chk("rip_lat1", {63'd0, m_axis_tvalid}, 64'd0);
    tick();
    chk("rip_lat2", {63'd0, m_axis_tvalid}, 64'd1);
    chk("rip_data", m_axis_tdata, fr(24'h0000AA, 24'h0000BB, 8'h00));
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
